// File: rtl/noc_pkt_monitor.sv
// Egress-side packet monitor for the BTree NoC: per-port and total delivery counts,
// destination-address checking, and cycle count from start to NUMPE*PktLimit packets.
module noc_pkt_monitor #(
    parameter int NUMPE       = 4,
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = $clog2(NUMPE),
    parameter int PktLimit    = 100,
    parameter int CycWidth    = 32,
    localparam int TotalWidth = DataWidth + AddrWidth,
    localparam int Exp        = NUMPE * PktLimit,
    localparam int CntWidth   = $clog2(Exp + 1)
) (
    input  logic                        clk100,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [NUMPE*TotalWidth-1:0] i_pe_data,
    input  logic [NUMPE-1:0]            i_pe_data_valid,
    input  logic [NUMPE-1:0]            i_pe_data_ready,
    output logic [1:0]                  o_state,
    output logic                        o_done,
    output logic [CntWidth-1:0]         o_total_pkts,
    output logic [NUMPE*CntWidth-1:0]   o_pe_pkts,
    output logic [CycWidth-1:0]         o_cycles,
    output logic                        o_addr_err,
    output logic [CntWidth-1:0]         o_addr_err_cnt,
    output logic                        o_overrun
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

    localparam logic [CntWidth:0] ExpFull = (CntWidth + 1)'(Exp);

    state_t              state_q, state_d;
    logic                clear, count, set_overrun;
    logic [NUMPE-1:0]    beat, misaddr;
    logic [CntWidth:0]   beat_cnt, misaddr_cnt, total_sum, err_sum;
    logic [CntWidth-1:0] total_q, err_cnt_q;
    logic [CntWidth-1:0] pe_cnt_q [NUMPE];
    logic [CycWidth-1:0] cycles_q;
    logic                addr_err_q, overrun_q, done_q;
    logic                unused_data;

    // Sums carry one spare bit so a total past all-ones clamps instead of wrapping.
    function automatic logic [CntWidth-1:0] sat(input logic [CntWidth:0] v);
        return v[CntWidth] ? '1 : v[CntWidth-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        beat        = '0;
        misaddr     = '0;
        beat_cnt    = '0;
        misaddr_cnt = '0;
        for (int p = 0; p < NUMPE; p++) begin
            beat[p]     = i_pe_data_valid[p] & i_pe_data_ready[p];
            misaddr[p]  = beat[p] &&
                          (i_pe_data[p*TotalWidth + DataWidth +: AddrWidth] != AddrWidth'(p));
            beat_cnt    = beat_cnt + (CntWidth + 1)'(beat[p]);
            misaddr_cnt = misaddr_cnt + (CntWidth + 1)'(misaddr[p]);
        end
        total_sum = {1'b0, total_q} + beat_cnt;
        err_sum   = {1'b0, err_cnt_q} + misaddr_cnt;
    end

    always_comb begin
        state_d     = state_q;
        clear       = 1'b0;
        count       = 1'b0;
        set_overrun = 1'b0;
        unique case (state_q)
            IDLE: if (i_start) begin
                clear   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                count = 1'b1;
                if (total_sum >= ExpFull) state_d = DONE;
                if (total_sum > ExpFull) set_overrun = 1'b1;
            end
            DONE: begin
                if (i_start) begin
                    clear   = 1'b1;
                    state_d = RUN;
                end else if (|beat) begin
                    set_overrun = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
        end
    end

    // NOTE: the per-port counter array is small flop storage that must read 0 after rst, so it is reset.
    always_ff @(posedge clk100) begin
        if (rst || clear) begin
            total_q    <= '0;
            err_cnt_q  <= '0;
            cycles_q   <= '0;
            addr_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int p = 0; p < NUMPE; p++) pe_cnt_q[p] <= '0;
        end else begin
            if (count) begin
                total_q   <= sat(total_sum);
                err_cnt_q <= sat(err_sum);
                if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
                if (|misaddr) addr_err_q <= 1'b1;
                for (int p = 0; p < NUMPE; p++)
                    if (beat[p] && pe_cnt_q[p] != '1) pe_cnt_q[p] <= pe_cnt_q[p] + 1'b1;
            end
            if (set_overrun) overrun_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUMPE; g++) begin : g_pack
        assign o_pe_pkts[g*CntWidth +: CntWidth] = pe_cnt_q[g];
    end

    // Payload bits are never inspected; only the address field matters here.
    assign unused_data    = ^i_pe_data;

    assign o_state        = state_q;
    assign o_done         = done_q;
    assign o_total_pkts   = total_q;
    assign o_cycles       = cycles_q;
    assign o_addr_err     = addr_err_q;
    assign o_addr_err_cnt = err_cnt_q;
    assign o_overrun      = overrun_q;
endmodule

// File: tb/tb_noc_pkt_monitor.sv
// Scoreboard bench for noc_pkt_monitor: a behavioural model pushes the expected
// outputs per driven cycle, popped and compared one edge later.
module tb_noc_pkt_monitor;
    localparam int NUMPE      = 4;
    localparam int DataWidth  = 32;
    localparam int AddrWidth  = 2;
    localparam int PktLimit   = 100;
    localparam int CycWidth   = 32;
    localparam int TotalWidth = DataWidth + AddrWidth;
    localparam int Exp        = NUMPE * PktLimit;
    localparam int CntWidth   = $clog2(Exp + 1);
    localparam int CntMax     = (1 << CntWidth) - 1;
    localparam logic [7:0] AddrOk = 8'b11_10_01_00;

    logic                        clk100 = 1'b0;
    logic                        rst;
    logic                        i_start;
    logic [NUMPE*TotalWidth-1:0] i_pe_data;
    logic [NUMPE-1:0]            i_pe_data_valid;
    logic [NUMPE-1:0]            i_pe_data_ready;
    logic [1:0]                  o_state;
    logic                        o_done;
    logic [CntWidth-1:0]         o_total_pkts;
    logic [NUMPE*CntWidth-1:0]   o_pe_pkts;
    logic [CycWidth-1:0]         o_cycles;
    logic                        o_addr_err;
    logic [CntWidth-1:0]         o_addr_err_cnt;
    logic                        o_overrun;

    noc_pkt_monitor #(
        .NUMPE(NUMPE), .DataWidth(DataWidth), .AddrWidth(AddrWidth),
        .PktLimit(PktLimit), .CycWidth(CycWidth)
    ) dut (
        .clk100(clk100), .rst(rst), .i_start(i_start),
        .i_pe_data(i_pe_data), .i_pe_data_valid(i_pe_data_valid),
        .i_pe_data_ready(i_pe_data_ready), .o_state(o_state), .o_done(o_done),
        .o_total_pkts(o_total_pkts), .o_pe_pkts(o_pe_pkts), .o_cycles(o_cycles),
        .o_addr_err(o_addr_err), .o_addr_err_cnt(o_addr_err_cnt), .o_overrun(o_overrun)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        int     st;
        int     total;
        int     pe[NUMPE];
        longint cyc;
        bit     err;
        int     errcnt;
        bit     ovr;
    } exp_t;

    exp_t   sb_q[$];
    int     m_st, m_total, m_errcnt;
    int     m_pe[NUMPE];
    longint m_cyc;
    bit     m_err, m_ovr;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic m_reset();
        m_st = 0; m_total = 0; m_errcnt = 0; m_cyc = 0; m_err = 0; m_ovr = 0;
        for (int p = 0; p < NUMPE; p++) m_pe[p] = 0;
    endtask

    task automatic compare(input exp_t e);
        check("sb_state", 64'(o_state), 64'(e.st));
        check("sb_done", 64'(o_done), 64'(e.st == 2));
        check("sb_total", 64'(o_total_pkts), 64'(e.total));
        check("sb_cycles", 64'(o_cycles), 64'(e.cyc));
        check("sb_addr_err", 64'(o_addr_err), 64'(e.err));
        check("sb_err_cnt", 64'(o_addr_err_cnt), 64'(e.errcnt));
        check("sb_overrun", 64'(o_overrun), 64'(e.ovr));
        for (int p = 0; p < NUMPE; p++)
            check($sformatf("sb_pe%0d", p), 64'(o_pe_pkts[p*CntWidth +: CntWidth]), 64'(m_pe_of(e, p)));
    endtask

    function automatic int m_pe_of(input exp_t e, input int p);
        return e.pe[p];
    endfunction

    // One clock: drive inputs at negedge, advance the model, compare just after posedge.
    task automatic step(input bit rs, input bit st, input logic [NUMPE-1:0] vl,
                        input logic [NUMPE-1:0] rd, input logic [2*NUMPE-1:0] addrs);
        exp_t e;
        int   n;
        @(negedge clk100);
        rst = rs; i_start = st; i_pe_data_valid = vl; i_pe_data_ready = rd;
        for (int p = 0; p < NUMPE; p++)
            i_pe_data[p*TotalWidth +: TotalWidth] = {addrs[2*p +: 2], DataWidth'($urandom)};
        if (rs) begin
            m_reset();
        end else begin
            case (m_st)
                0: if (st) begin m_reset(); m_st = 1; end
                1: begin
                    n = 0;
                    if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
                    for (int p = 0; p < NUMPE; p++) begin
                        if (vl[p] && rd[p]) begin
                            n++;
                            m_pe[p] = min_i(m_pe[p] + 1, CntMax);
                            if (int'(addrs[2*p +: 2]) != p) begin
                                m_err = 1;
                                m_errcnt = min_i(m_errcnt + 1, CntMax);
                            end
                        end
                    end
                    if (m_total + n >= Exp) begin
                        m_st = 2;
                        if (m_total + n > Exp) m_ovr = 1;
                    end
                    m_total = min_i(m_total + n, CntMax);
                end
                default: begin
                    if (st) begin m_reset(); m_st = 1; end
                    else if ((vl & rd) != '0) m_ovr = 1;
                end
            endcase
        end
        e.st = m_st; e.total = m_total; e.cyc = m_cyc; e.err = m_err;
        e.errcnt = m_errcnt; e.ovr = m_ovr;
        for (int p = 0; p < NUMPE; p++) e.pe[p] = m_pe[p];
        sb_q.push_back(e);
        @(posedge clk100);
        #1;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty got=0 expected=1");
        end else begin
            compare(sb_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_pe_data = '0;
        i_pe_data_valid = '0; i_pe_data_ready = '0;
        m_reset();

        step(1, 0, 4'h0, 4'h0, AddrOk);
        step(1, 0, 4'h0, 4'h0, AddrOk);
        check("rst_state", 64'(o_state), 0);
        check("rst_total", 64'(o_total_pkts), 0);
        check("rst_cycles", 64'(o_cycles), 0);
        step(0, 0, 4'hF, 4'hF, AddrOk);
        check("idle_ignore", 64'(o_total_pkts), 0);

        // Single port, 400 consecutive beats.
        step(0, 1, 4'h0, 4'h0, AddrOk);
        check("start_run", 64'(o_state), 1);
        for (int i = 0; i < Exp - 1; i++) step(0, 0, 4'b0001, 4'b0001, AddrOk);
        check("single_not_done", 64'(o_done), 0);
        step(0, 0, 4'b0001, 4'b0001, AddrOk);
        check("single_done", 64'(o_done), 1);
        check("single_cycles", 64'(o_cycles), 400);
        check("single_pe0", 64'(o_pe_pkts[0 +: CntWidth]), 400);
        check("single_addr_err", 64'(o_addr_err), 0);
        check("single_overrun", 64'(o_overrun), 0);

        // Beat in DONE, then restart with beats that must be discarded.
        step(0, 0, 4'b0001, 4'b0001, AddrOk);
        check("done_beat_ovr", 64'(o_overrun), 1);
        check("done_beat_total", 64'(o_total_pkts), 400);
        step(0, 1, 4'hF, 4'hF, AddrOk);
        check("restart_state", 64'(o_state), 1);
        check("restart_total", 64'(o_total_pkts), 0);
        check("restart_ovr", 64'(o_overrun), 0);

        // Back-pressure on port 2 (ready 1010...).
        for (int i = 0; i < 200 && m_st == 1; i++)
            step(0, 0, 4'hF, (i % 2 == 0) ? 4'hF : 4'b1011, AddrOk);
        check("bp_done", 64'(o_done), 1);
        check("bp_cycles", 64'(o_cycles), 115);
        check("bp_pe2", 64'(o_pe_pkts[2*CntWidth +: CntWidth]), 58);
        check("bp_total", 64'(o_total_pkts), 403);

        // Misaddressed packet on port 3, then parallel final beats.
        step(0, 1, 4'h0, 4'h0, AddrOk);
        step(0, 0, 4'b1000, 4'b1000, 8'b01_10_01_00);
        check("aerr_flag", 64'(o_addr_err), 1);
        check("aerr_cnt", 64'(o_addr_err_cnt), 1);
        check("aerr_pe3", 64'(o_pe_pkts[3*CntWidth +: CntWidth]), 1);
        repeat (99) step(0, 0, 4'hF, 4'hF, AddrOk);
        step(0, 0, 4'b0001, 4'b0001, AddrOk);
        check("par_pre_total", 64'(o_total_pkts), 398);
        check("par_pre_state", 64'(o_state), 1);
        step(0, 0, 4'b1110, 4'b1110, AddrOk);
        check("par_total", 64'(o_total_pkts), 401);
        check("par_ovr", 64'(o_overrun), 1);
        check("par_state", 64'(o_state), 2);

        // Reset in the middle of a run.
        step(0, 1, 4'h0, 4'h0, AddrOk);
        repeat (37) step(0, 0, 4'hF, 4'hF, AddrOk);
        step(0, 0, 4'b0011, 4'b0011, AddrOk);
        check("mid_total", 64'(o_total_pkts), 150);
        step(1, 0, 4'hF, 4'hF, AddrOk);
        check("mid_rst_state", 64'(o_state), 0);
        check("mid_rst_total", 64'(o_total_pkts), 0);
        check("mid_rst_pe", 64'(o_pe_pkts), 0);
        repeat (3) step(0, 0, 4'hF, 4'hF, AddrOk);
        check("mid_idle_total", 64'(o_total_pkts), 0);
        step(0, 1, 4'h0, 4'h0, AddrOk);
        step(0, 0, 4'hF, 4'hF, AddrOk);
        check("post_total", 64'(o_total_pkts), 4);
        check("post_cycles", 64'(o_cycles), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
